// File: rtl/rl_ram_1r1w_bypass.sv
`default_nettype none
// ============================================================================
// Module   : rl_ram_1r1w_bypass
// Brief    : Inferrable 1R1W RAM with read enable, read-data valid,
//            selectable read latency (1 or 2) and byte-granular
//            read-during-write forwarding done in registered side logic.
//            Optional per-lane even parity: define RL_RAM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rl_ram_1r1w_bypass #(
    parameter int    ABITS     = 10,
    parameter int    DBITS     = 32,
    parameter int    LATENCY   = 1,
    parameter int    BYPASS    = 1,
    parameter string INIT_FILE = ""
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [ABITS-1:0]       waddr_i,
    input  logic [DBITS-1:0]       din_i,
    input  logic                   we_i,
    input  logic [(DBITS+7)/8-1:0] be_i,
    input  logic [ABITS-1:0]       raddr_i,
    input  logic                   re_i,
    output logic [DBITS-1:0]       dout_o,
    output logic                   dvalid_o,
    output logic                   perr_o
);

    localparam int   c_lanes  = (DBITS + 7) / 8;
    localparam int   c_depth  = 1 << ABITS;
`ifdef RL_RAM_PARITY_EN
    localparam int   c_pbits  = c_lanes;
`else
    localparam int   c_pbits  = 0;
`endif
    localparam int   c_wbits  = DBITS + c_pbits;
    localparam logic c_bypass = (BYPASS != 0);

    // Storage: data in the low DBITS, per-lane parity (if enabled) above it.
    logic [c_wbits-1:0] r_mem [c_depth];
    logic [c_wbits-1:0] r_raw;

    // Collision side registers captured alongside each array read.
    logic               r_col;
    logic [DBITS-1:0]   r_col_din;
    logic [c_lanes-1:0] r_col_be;
    logic               r_v1;
    logic               r_seen;

    logic [c_wbits-1:0] w_wdata;
    logic [c_wbits-1:0] w_wmask;
    logic [c_lanes-1:0] w_fwd;
    logic [DBITS-1:0]   w_merged;
    logic [DBITS-1:0]   w_dout1;
    logic               w_perr1;
`ifdef RL_RAM_PARITY_EN
    logic [c_lanes-1:0] w_lane_err;
`endif

    // Per-lane write word/mask, forwarding merge and parity check.
    for (genvar l = 0; l < c_lanes; l++) begin : g_lane
        localparam int c_lo = 8 * l;
        localparam int c_w  = (l == c_lanes - 1) ? (DBITS - 8 * l) : 8;

        assign w_wdata[c_lo +: c_w]  = din_i[c_lo +: c_w];
        assign w_wmask[c_lo +: c_w]  = {c_w{be_i[l]}};
        assign w_fwd[l]              = r_col & r_col_be[l];
        assign w_merged[c_lo +: c_w] = w_fwd[l] ? r_col_din[c_lo +: c_w]
                                                : r_raw[c_lo +: c_w];
`ifdef RL_RAM_PARITY_EN
        // Even parity: stored bit makes the lane plus parity have even weight.
        assign w_wdata[DBITS + l] = ^din_i[c_lo +: c_w];
        assign w_wmask[DBITS + l] = be_i[l];
        // Forwarded lanes never came from the array, so they are never flagged.
        assign w_lane_err[l] = ((^r_raw[c_lo +: c_w]) ^ r_raw[DBITS + l]) & ~w_fwd[l];
`endif
    end

`ifdef RL_RAM_PARITY_EN
    assign w_perr1 = r_v1 & (|w_lane_err);
`else
    assign w_perr1 = 1'b0;
`endif

    // Stage-1 output is forced to zero until the first read after reset,
    // since the raw read register is part of the array and is not reset.
    assign w_dout1 = r_seen ? w_merged : '0;

    // Array write: only enabled lanes (and their parity bits) are updated.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < c_wbits; b++) begin
                if (w_wmask[b]) begin
                    r_mem[waddr_i][b] <= w_wdata[b];
                end
            end
        end
    end

    // Array read: plain synchronous read returning old contents.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            r_raw <= r_mem[raddr_i];
        end
    end

    // Stage-1 control: valid flag and collision capture for forwarding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v1      <= 1'b0;
            r_seen    <= 1'b0;
            r_col     <= 1'b0;
            r_col_din <= '0;
            r_col_be  <= '0;
        end else begin
            r_v1 <= re_i;
            if (re_i) begin
                r_seen    <= 1'b1;
                r_col     <= we_i && (waddr_i == raddr_i) && c_bypass;
                r_col_din <= din_i;
                r_col_be  <= be_i;
            end
        end
    end

    if (LATENCY == 1) begin : g_lat1
        assign dout_o   = w_dout1;
        assign dvalid_o = r_v1;
        assign perr_o   = w_perr1;
    end else if (LATENCY == 2) begin : g_lat2
        logic [DBITS-1:0] r_dout2;
        logic             r_v2;
        logic             r_perr2;

        // Stage-2 output register; holds its value when no read completes.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_dout2 <= '0;
                r_v2    <= 1'b0;
                r_perr2 <= 1'b0;
            end else begin
                r_v2    <= r_v1;
                r_perr2 <= w_perr1;
                if (r_v1) begin
                    r_dout2 <= w_dout1;
                end
            end
        end

        assign dout_o   = r_dout2;
        assign dvalid_o = r_v2;
        assign perr_o   = r_perr2;
    end else begin : g_bad_latency
        $fatal(1, "rl_ram_1r1w_bypass: LATENCY must be 1 or 2");
        assign dout_o   = '0;
        assign dvalid_o = 1'b0;
        assign perr_o   = 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_rl_ram_1r1w_bypass.sv
`default_nettype none
// ============================================================================
// Module   : tb_rl_ram_1r1w_bypass
// Brief    : Scoreboard bench for rl_ram_1r1w_bypass. Three instances share
//            one stimulus stream: (LATENCY=1,BYPASS=1), (LATENCY=2,BYPASS=1),
//            (LATENCY=1,BYPASS=0). Parity checks active with RL_RAM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rl_ram_1r1w_bypass;

`ifdef RL_RAM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  waddr = '0;
    logic [9:0]  raddr = '0;
    logic [31:0] din   = '0;
    logic        we    = 1'b0;
    logic        re    = 1'b0;
    logic [3:0]  be    = '0;

    logic [31:0] dout_a, dout_b, dout_c;
    logic        dv_a, dv_b, dv_c;
    logic        pe_a, pe_b, pe_c;

    rl_ram_1r1w_bypass #(.ABITS(10), .DBITS(32), .LATENCY(1), .BYPASS(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
        .raddr_i(raddr), .re_i(re), .dout_o(dout_a), .dvalid_o(dv_a), .perr_o(pe_a));
    rl_ram_1r1w_bypass #(.ABITS(10), .DBITS(32), .LATENCY(2), .BYPASS(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
        .raddr_i(raddr), .re_i(re), .dout_o(dout_b), .dvalid_o(dv_b), .perr_o(pe_b));
    rl_ram_1r1w_bypass #(.ABITS(10), .DBITS(32), .LATENCY(1), .BYPASS(0)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .waddr_i(waddr), .din_i(din), .we_i(we), .be_i(be),
        .raddr_i(raddr), .re_i(re), .dout_o(dout_c), .dvalid_o(dv_c), .perr_o(pe_c));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: contents, which bits are defined, which lanes are corrupt.
    logic [31:0] m_mem   [1024];
    logic [31:0] m_known [1024];
    logic [3:0]  m_bad   [1024];

    typedef struct {
        logic [31:0] d;
        logic [31:0] m;
        logic        p;
        int          c;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    logic [31:0] last_d [3];
    logic [31:0] last_m [3];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, req, $time);
    endtask

    // Read result as seen by a reader: forwarded lanes come from din, others from memory.
    function automatic exp_t model_read(input logic [9:0] a, input logic [3:0] fwd, input logic [31:0] d);
        exp_t e;
        e.p = 1'b0;
        e.c = 0;
        for (int l = 0; l < 4; l++) begin
            if (fwd[l]) begin
                e.d[l*8 +: 8] = d[l*8 +: 8];
                e.m[l*8 +: 8] = 8'hFF;
            end else begin
                e.d[l*8 +: 8] = m_mem[a][l*8 +: 8];
                e.m[l*8 +: 8] = m_known[a][l*8 +: 8];
                if (m_bad[a][l]) e.p = PAR_EN;
            end
        end
        return e;
    endfunction

    // One clock of stimulus; expectations are queued at issue time.
    task automatic drive(input logic w, input logic [3:0] b, input logic [9:0] wa,
                         input logic [31:0] d, input logic r, input logic [9:0] ra);
        exp_t e1;
        exp_t e0;
        logic [3:0] fwd;
        @(posedge clk);
        #1;
        we = w; be = b; waddr = wa; din = d; re = r; raddr = ra;
        if (r) begin
            fwd = (w && (wa == ra)) ? b : 4'h0;
            e1 = model_read(ra, fwd, d);
            e0 = model_read(ra, 4'h0, d);
            e1.c = cyc + 1; q_a.push_back(e1);
            e1.c = cyc + 2; q_b.push_back(e1);
            e0.c = cyc + 1; q_c.push_back(e0);
        end
        if (w) begin
            for (int l = 0; l < 4; l++) begin
                if (b[l]) begin
                    m_mem[wa][l*8 +: 8]   = d[l*8 +: 8];
                    m_known[wa][l*8 +: 8] = 8'hFF;
                    m_bad[wa][l]          = 1'b0;
                end
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 10'h0, 32'h0, 1'b0, 10'h0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0; rst_n = 1'b0;
        q_a.delete(); q_b.delete(); q_c.delete();
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic mon(input int k, input logic [31:0] d, input logic v, input logic p);
        exp_t e;
        int   sz;
        case (k)
            0:       sz = q_a.size();
            1:       sz = q_b.size();
            default: sz = q_c.size();
        endcase
        if (v) begin
            if (sz == 0) begin
                chk(1'b0, $sformatf("dut%0d_unexpected_dvalid", k), {31'b0, v}, 32'h0);
            end else begin
                case (k)
                    0:       e = q_a.pop_front();
                    1:       e = q_b.pop_front();
                    default: e = q_c.pop_front();
                endcase
                chk(((d ^ e.d) & e.m) == 32'h0, $sformatf("dut%0d_data", k), d, e.d);
                chk(p == e.p, $sformatf("dut%0d_perr", k), {31'b0, p}, {31'b0, e.p});
                chk(cyc == e.c, $sformatf("dut%0d_latency_cycle", k), 32'(cyc), 32'(e.c));
                last_d[k] = e.d;
                last_m[k] = e.m;
            end
        end else begin
            chk(((d ^ last_d[k]) & last_m[k]) == 32'h0, $sformatf("dut%0d_hold", k), d, last_d[k]);
            chk(p == 1'b0, $sformatf("dut%0d_perr_idle", k), {31'b0, p}, 32'h0);
        end
    endtask

    // Monitor: compares every output cycle against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, dout_a, dv_a, pe_a);
            mon(1, dout_b, dv_b, pe_b);
            mon(2, dout_c, dv_c, pe_c);
        end else begin
            chk(dout_a == 0 && !dv_a && !pe_a, "reset_state_a", dout_a, 32'h0);
            chk(dout_b == 0 && !dv_b && !pe_b, "reset_state_b", dout_b, 32'h0);
            chk(dout_c == 0 && !dv_c && !pe_c, "reset_state_c", dout_c, 32'h0);
            for (int k = 0; k < 3; k++) begin
                last_d[k] = 32'h0;
                last_m[k] = 32'hFFFF_FFFF;
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            m_mem[i] = 32'h0; m_known[i] = 32'h0; m_bad[i] = 4'h0;
        end
        do_reset(3);
        repeat (10) idle();

        // Full write then read.
        drive(1'b1, 4'hF, 10'h005, 32'hDEADBEEF, 1'b0, 10'h0);
        drive(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 10'h005);
        idle();
        chk(dv_a && dout_a == 32'hDEADBEEF, "l1_full_write_read", dout_a, 32'hDEADBEEF);
        idle();
        chk(dv_b && dout_b == 32'hDEADBEEF, "l2_full_write_read", dout_b, 32'hDEADBEEF);

        // Partial write.
        drive(1'b1, 4'b0101, 10'h005, 32'h11223344, 1'b0, 10'h0);
        drive(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 10'h005);
        idle();
        chk(dv_a && dout_a == 32'hDE22BE44, "partial_write", dout_a, 32'hDE22BE44);
        idle();

        // Same-edge collision.
        drive(1'b1, 4'hF, 10'h3FF, 32'h0, 1'b0, 10'h0);
        drive(1'b1, 4'b1100, 10'h3FF, 32'hAABBCCDD, 1'b1, 10'h3FF);
        idle();
        chk(dv_a && dout_a == 32'hAABB0000, "collision_bypass1", dout_a, 32'hAABB0000);
        chk(dv_c && dout_c == 32'h00000000, "collision_bypass0", dout_c, 32'h0);
        drive(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 10'h3FF);
        idle();
        chk(dv_c && dout_c == 32'hAABB0000, "collision_followup", dout_c, 32'hAABB0000);
        repeat (2) idle();

        // Streaming reads.
        for (int n = 0; n < 8; n++) drive(1'b1, 4'hF, 10'(n), 32'(n), 1'b0, 10'h0);
        for (int n = 0; n < 8; n++) drive(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 10'(n));
        repeat (3) idle();

`ifdef RL_RAM_PARITY_EN
        drive(1'b1, 4'hF, 10'h010, 32'h12345678, 1'b0, 10'h0);
        idle();
        dut_a.r_mem[16][0] = ~dut_a.r_mem[16][0];
        dut_b.r_mem[16][0] = ~dut_b.r_mem[16][0];
        dut_c.r_mem[16][0] = ~dut_c.r_mem[16][0];
        m_mem[16][0] = ~m_mem[16][0];
        m_bad[16][0] = 1'b1;
        drive(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 10'h010);
        idle();
        chk(dv_a && pe_a, "parity_error_flagged", {31'b0, pe_a}, 32'h1);
        drive(1'b1, 4'hF, 10'h010, 32'h12345678, 1'b0, 10'h0);
        drive(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 10'h010);
        idle();
        chk(dv_a && !pe_a, "parity_cleared_by_rewrite", {31'b0, pe_a}, 32'h0);
        repeat (2) idle();
`endif

        // Randomised traffic over a small address window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                drive(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 10'h003);
                drive(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 10'h004);
                do_reset(2);
                repeat (10) idle();
            end
            drive(1'($urandom_range(0, 1)), 4'($urandom), 10'($urandom_range(0, 15)),
                  32'($urandom), ($urandom_range(0, 9) < 7), 10'($urandom_range(0, 15)));
        end
        repeat (5) idle();

        chk(q_a.size() == 0, "dut0_pending_reads", 32'(q_a.size()), 32'h0);
        chk(q_b.size() == 0, "dut1_pending_reads", 32'(q_b.size()), 32'h0);
        chk(q_c.size() == 0, "dut2_pending_reads", 32'(q_c.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
